// File: rtl/regfile_wr_arbiter_if.sv
// Register-file write arbiter bus: ALU writeback request, memory-load return
// request, the arbitrated register-file write port and the busy scoreboard.
interface regfile_wr_arbiter_if #(
    parameter int W = 8,
    parameter int D = 4
);
    logic             alu_valid;
    logic [D-1:0]     alu_addr;
    logic [W-1:0]     alu_data;
    logic             alu_ready;
    logic             mem_valid;
    logic [D-1:0]     mem_addr;
    logic [W-1:0]     mem_data;
    logic             mem_ready;
    logic             wr_en;
    logic [D-1:0]     wr_addr;
    logic [W-1:0]     wr_data;
    logic [2**D-1:0]  busy_mask;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        input  alu_ready, mem_ready,
        input  wr_en, wr_addr, wr_data, busy_mask
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        output alu_ready, mem_ready,
        output wr_en, wr_addr, wr_data, busy_mask
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Register-file write arbiter: one write port shared by the ALU writeback path
// and a 2-entry load-return FIFO. ALU writes land one cycle after grant; loads
// are pushed first and popped on a later cycle. An ALU write that would overtake
// a buffered load to the same register is held off until the load has written.
// Optional macro RR_ARB_EN: round-robin between ALU and FIFO when both are
// eligible; without it the ALU has fixed priority.
//
// last-grant state (RR_ARB_EN only):
//   state      | meaning
//   GRANT_MEM  | FIFO won the last grant (reset value), ALU favoured next
//   GRANT_ALU  | ALU won the last grant, FIFO favoured next
module regfile_wr_arbiter #(
    parameter int W = 8,
    parameter int D = 4
) (
    input logic                clk,
    input logic                rst_n,
    regfile_wr_arbiter_if.slave bus
);
    logic [1:0]   count;
    logic         wr_ptr;
    logic         rd_ptr;
    logic [D-1:0] ent_addr [2];
    logic [W-1:0] ent_data [2];
    logic [1:0]   ent_valid;
    logic         waw_hit;
    logic         alu_elig;
    logic         fifo_elig;
    logic         grant_alu;
    logic         grant_fifo;
    logic         push;
    logic         pop;

`ifdef RR_ARB_EN
    typedef enum logic {GRANT_MEM = 1'b0, GRANT_ALU = 1'b1} last_grant_t;
    last_grant_t last_grant;
`endif

    // Which FIFO slots hold a live load, from registered count and read pointer.
    always_comb begin
        ent_valid = 2'b00;
        if (count == 2'd2) begin
            ent_valid = 2'b11;
        end else if (count == 2'd1) begin
            ent_valid[rd_ptr] = 1'b1;
        end
    end

    assign waw_hit = (ent_valid[0] && (ent_addr[0] == bus.alu_addr)) ||
                     (ent_valid[1] && (ent_addr[1] == bus.alu_addr));

    // Arbitration: a full FIFO or a pending load to the same register blocks the ALU.
    always_comb begin
        alu_elig  = bus.alu_valid && (count != 2'd2) && !waw_hit;
        fifo_elig = (count != 2'd0);
        grant_alu = alu_elig;
`ifdef RR_ARB_EN
        if (alu_elig && fifo_elig && (last_grant == GRANT_ALU)) begin
            grant_alu = 1'b0;
        end
`endif
        grant_fifo = fifo_elig && !grant_alu;
    end

    assign bus.alu_ready = grant_alu;
    assign bus.mem_ready = (count != 2'd2);
    assign push          = bus.mem_valid && (count != 2'd2);
    assign pop           = grant_fifo;

    // Scoreboard of registers that still have a buffered load outstanding.
    always_comb begin
        bus.busy_mask = '0;
        for (int i = 0; i < 2; i++) begin
            if (ent_valid[i]) begin
                bus.busy_mask[ent_addr[i]] = 1'b1;
            end
        end
    end

    // Load FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            ent_addr[0] <= '0;
            ent_addr[1] <= '0;
            ent_data[0] <= '0;
            ent_data[1] <= '0;
        end else begin
            if (push) begin
                ent_addr[wr_ptr] <= bus.mem_addr;
                ent_data[wr_ptr] <= bus.mem_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Registered write port; address/data hold when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            bus.wr_en <= grant_alu || grant_fifo;
            if (grant_alu) begin
                bus.wr_addr <= bus.alu_addr;
                bus.wr_data <= bus.alu_data;
            end else if (grant_fifo) begin
                bus.wr_addr <= ent_addr[rd_ptr];
                bus.wr_data <= ent_data[rd_ptr];
            end
        end
    end

`ifdef RR_ARB_EN
    // Remember who won last so contention alternates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GRANT_MEM;
        end else if (grant_alu) begin
            last_grant <= GRANT_ALU;
        end else if (grant_fifo) begin
            last_grant <= GRANT_MEM;
        end
    end
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios with literal expectations,
// then randomized traffic and resets checked against a queue-based model.
module tb_regfile_wr_arbiter;
    localparam int W = 8;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.W(W), .D(D)) bus ();
    regfile_wr_arbiter #(.W(W), .D(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [D-1:0] addr;
        logic [W-1:0] data;
    } load_t;

    load_t        q[$];
    int           checks = 0;
    int           errors = 0;
    logic         m_wr_en = 1'b0;
    logic [D-1:0] m_wr_addr = '0;
    logic [W-1:0] m_wr_data = '0;
    bit           m_last_alu = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] m;
        m = '0;
        foreach (q[i]) m[q[i].addr] = 1'b1;
        return m;
    endfunction

    task automatic drive(input logic av, input logic [D-1:0] aa, input logic [W-1:0] ad,
                         input logic mv, input logic [D-1:0] ma, input logic [W-1:0] md);
        bus.alu_valid = av;
        bus.alu_addr  = aa;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_addr  = ma;
        bus.mem_data  = md;
    endtask

    // One clock period: check registered outputs, apply inputs, check the
    // combinational grant, then advance the model across the coming edge.
    task automatic cycle(input logic av, input logic [D-1:0] aa, input logic [W-1:0] ad,
                         input logic mv, input logic [D-1:0] ma, input logic [W-1:0] md);
        bit    blocked, ae, fe, ga, gf, mr;
        load_t e;
        @(negedge clk);
        chk("wr_en", 32'(bus.wr_en), 32'(m_wr_en));
        chk("wr_addr", 32'(bus.wr_addr), 32'(m_wr_addr));
        chk("wr_data", 32'(bus.wr_data), 32'(m_wr_data));
        chk("busy_mask", 32'(bus.busy_mask), model_busy());
        chk("mem_ready", 32'(bus.mem_ready), 32'(q.size() < 2));
        drive(av, aa, ad, mv, ma, md);
        #1;
        blocked = (q.size() == 2);
        foreach (q[i]) if (q[i].addr == aa) blocked = 1'b1;
        ae = av && !blocked;
        fe = (q.size() > 0);
`ifdef RR_ARB_EN
        ga = ae && !(fe && m_last_alu);
`else
        ga = ae;
`endif
        gf = fe && !ga;
        chk("alu_ready", 32'(bus.alu_ready), 32'(ga));
        mr = (q.size() < 2);
        if (ga) begin
            m_wr_en = 1'b1; m_wr_addr = aa; m_wr_data = ad;
        end else if (gf) begin
            m_wr_en = 1'b1; m_wr_addr = q[0].addr; m_wr_data = q[0].data;
            void'(q.pop_front());
        end else begin
            m_wr_en = 1'b0;
        end
        if (ga || gf) m_last_alu = ga;
        if (mv && mr) begin
            e.addr = ma; e.data = md;
            q.push_back(e);
        end
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic peek();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wr_en", 32'(bus.wr_en), 32'h0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 32'h0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'h0);
        chk("rst_busy_mask", 32'(bus.busy_mask), 32'h0);
        chk("rst_mem_ready", 32'(bus.mem_ready), 32'h1);
        q.delete();
        m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0; m_last_alu = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        do_reset();

        // ALU only
        cycle(1'b1, 4'd3, 8'h5A, 1'b0, '0, '0);
        chk("alu_only_ready", 32'(bus.alu_ready), 32'h1);
        peek();
        chk("alu_only_wr_en", 32'(bus.wr_en), 32'h1);
        chk("alu_only_wr_addr", 32'(bus.wr_addr), 32'h3);
        chk("alu_only_wr_data", 32'(bus.wr_data), 32'h5A);

        // Single load while ALU idle
        cycle(1'b0, '0, '0, 1'b1, 4'd7, 8'hC3);
        chk("load_mem_ready", 32'(bus.mem_ready), 32'h1);
        peek();
        chk("load_busy_set", 32'(bus.busy_mask), 32'h0080);
        chk("load_no_write_yet", 32'(bus.wr_en), 32'h0);
        idle();
        peek();
        chk("load_wr_en", 32'(bus.wr_en), 32'h1);
        chk("load_wr_addr", 32'(bus.wr_addr), 32'h7);
        chk("load_wr_data", 32'(bus.wr_data), 32'hC3);
        chk("load_busy_clear", 32'(bus.busy_mask), 32'h0);

        // Fill the FIFO while the ALU keeps writing register 9
        cycle(1'b1, 4'd9, 8'h11, 1'b1, 4'd1, 8'hA1);
        cycle(1'b1, 4'd9, 8'h12, 1'b1, 4'd2, 8'hA2);
`ifdef RR_ARB_EN
        cycle(1'b1, 4'd9, 8'h13, 1'b1, 4'd3, 8'hA3);
`endif
        cycle(1'b1, 4'd9, 8'h14, 1'b1, 4'd4, 8'hA4);
        chk("full_alu_ready", 32'(bus.alu_ready), 32'h0);
        chk("full_mem_ready", 32'(bus.mem_ready), 32'h0);
        peek();
        chk("full_wr_en", 32'(bus.wr_en), 32'h1);
`ifdef RR_ARB_EN
        chk("full_head_addr", 32'(bus.wr_addr), 32'h2);
`else
        chk("full_head_addr", 32'(bus.wr_addr), 32'h1);
`endif
        repeat (3) idle();

        // WAW hold-off
        cycle(1'b0, '0, '0, 1'b1, 4'd5, 8'hB5);
        cycle(1'b1, 4'd5, 8'h55, 1'b0, '0, '0);
        chk("waw_blocked", 32'(bus.alu_ready), 32'h0);
        peek();
        chk("waw_load_addr", 32'(bus.wr_addr), 32'h5);
        chk("waw_load_data", 32'(bus.wr_data), 32'hB5);
        cycle(1'b1, 4'd5, 8'h55, 1'b0, '0, '0);
        chk("waw_released", 32'(bus.alu_ready), 32'h1);
        peek();
        chk("waw_alu_data", 32'(bus.wr_data), 32'h55);

        // Contention between a steady ALU stream and one buffered load
        cycle(1'b1, 4'd4, 8'h44, 1'b1, 4'd6, 8'hC6);
        cycle(1'b1, 4'd4, 8'h45, 1'b0, '0, '0);
`ifdef RR_ARB_EN
        chk("contend_alu_ready", 32'(bus.alu_ready), 32'h0);
        peek();
        chk("contend_wr_addr", 32'(bus.wr_addr), 32'h6);
`else
        chk("contend_alu_ready", 32'(bus.alu_ready), 32'h1);
        peek();
        chk("contend_wr_addr", 32'(bus.wr_addr), 32'h4);
`endif
        cycle(1'b1, 4'd4, 8'h46, 1'b0, '0, '0);
        chk("contend_alu_ready2", 32'(bus.alu_ready), 32'h1);
`ifdef RR_ARB_EN
        chk("contend_busy2", 32'(bus.busy_mask), 32'h0);
`else
        chk("contend_busy2", 32'(bus.busy_mask), 32'h0040);
`endif
        repeat (2) idle();

        // Reset with loads buffered
        cycle(1'b1, 4'd10, 8'h21, 1'b1, 4'd11, 8'hB1);
        cycle(1'b1, 4'd10, 8'h22, 1'b1, 4'd12, 8'hB2);
`ifdef RR_ARB_EN
        cycle(1'b1, 4'd10, 8'h23, 1'b1, 4'd13, 8'hB3);
`endif
        do_reset();
        repeat (3) idle();
        chk("post_reset_no_write", 32'(bus.wr_en), 32'h0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 3) != 0), D'($urandom_range(0, 5)), W'($urandom),
                      1'($urandom_range(0, 1)), D'($urandom_range(0, 5)), W'($urandom));
            end
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter W, default 8, register data width.
REQ-002 SHALL have parameter D, default 4, register address width (2**D registers).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port alu_valid  input  1  ALU writeback request.
REQ-006 SHALL have port alu_addr  input  D  ALU destination register.
REQ-007 SHALL have port alu_data  input  W  ALU result.
REQ-008 SHALL have port alu_ready  output  1  ALU request granted this cycle.
REQ-009 SHALL have port mem_valid  input  1  memory-load return request.
REQ-010 SHALL have port mem_addr  input  D  load destination register.
REQ-011 SHALL have port mem_data  input  W  load data.
REQ-012 SHALL have port mem_ready  output  1  load accepted into buffer this cycle.
REQ-013 SHALL have port wr_en  output  1  register-file write strobe, registered.
REQ-014 SHALL have port wr_addr  output  D  register-file write address, registered.
REQ-015 SHALL have port wr_data  output  W  register-file write data, registered.
REQ-016 SHALL have port busy_mask  output  2**D  bit n set while a buffered load targets register n.

Function
REQ-017 SHALL buffer loads in a 2-entry FIFO; transfer when mem_valid && mem_ready; mem_ready = (count < 2), from registered count only.
REQ-018 SHALL grant at most one source per cycle to the single write port.
REQ-019 SHALL block ALU (alu_ready=0) when FIFO full or alu_addr equals any valid FIFO entry address (WAW ordering); FIFO granted instead.
REQ-020 Otherwise, fixed-priority mode SHALL grant ALU when alu_valid, else FIFO head when count > 0.
REQ-021 alu_ready SHALL be combinational from alu_valid, alu_addr and registered state; ALU transfer when alu_valid && alu_ready.
REQ-022 Granted source SHALL appear on wr_en/wr_addr/wr_data the next cycle: ALU latency 1, load latency >= 2 (push, then pop).
REQ-023 wr_en SHALL be 0 in any cycle following a cycle with no grant; wr_addr/wr_data hold last values.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-025 FIFO pointers SHALL wrap modulo 2; count SHALL never exceed 2 or underflow.
REQ-026 busy_mask SHALL be the OR of one-hot decodes of valid FIFO entry addresses, registered-state derived.

Reset
REQ-027 rst_n low SHALL immediately clear wr_en, wr_addr, wr_data, FIFO count/pointers, busy_mask, and set rr last-grant to MEM.
REQ-028 Reset mid-operation SHALL discard buffered loads; no write issued for them after release.
REQ-029 First rising edge after rst_n release SHALL operate normally.

Configuration
REQ-030 With RR_ARB_EN defined, when ALU and FIFO both eligible, grant SHALL alternate, favouring the source not granted last; REQ-019 blocking still overrides.
REQ-031 Without RR_ARB_EN, arbitration SHALL be fixed priority per REQ-020 and no last-grant state exists.

Verification
REQ-032 ALU only: alu_valid=1, addr=3, data=0x5A -> alu_ready=1 same cycle; next cycle wr_en=1, wr_addr=3, wr_data=0x5A.
REQ-033 Load while ALU idle: mem addr=7, data=0xC3 -> mem_ready=1, busy_mask[7]=1 next cycle; write of 7/0xC3 two cycles after accept; busy_mask clears.
REQ-034 Full FIFO: two loads (addr 1,2) with ALU continuously valid addr 9 -> mem_ready=0, alu_ready=0; FIFO writes 1 then 2 before ALU write to 9.
REQ-035 WAW: buffered load addr 5, ALU addr 5 valid -> alu_ready=0 until load writes 5; ALU write to 5 strictly after.
REQ-036 RR_ARB_EN: ALU valid continuously (addr 4), one buffered load (addr 6) -> writes alternate ALU, load, ALU; without macro ALU every cycle while FIFO holds 1 entry.
REQ-037 Reset with two buffered loads -> wr_en=0, busy_mask=0, mem_ready=1 immediately; no write to those addresses after release.
